usb_ep_in_fifo: RTL and testbench
=================================

USB_EP_IN_FIFO -- requirements
Module: usb_ep_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, entry count; power of two, minimum 4.
REQ-002 SHALL have parameter EP_DATA_WID, default 8, byte width matching the protocol engine endpoint data width.
REQ-003 SHALL have port clk48_i, input, 1: the only clock; all logic is synchronous to it.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port wrData_i, input, EP_DATA_WID: application byte to push.
REQ-006 SHALL have port wrValid_i, input, 1: push request; accepted when wrValid_i && wrReady_o.
REQ-007 SHALL have port wrReady_o, output, 1: at least one free entry, counted against the committed read pointer.
REQ-008 SHALL have port freeCount_o, output, $clog2(DEPTH)+1: free entries, counted against the committed read pointer.
REQ-009 SHALL have port popData_i, input, 1: protocol engine consumes data_o (speculative pop).
REQ-010 SHALL have port popTransDone_i, input, 1: one-cycle pulse at the end of the IN transaction.
REQ-011 SHALL have port popTransSuccess_i, input, 1: sampled with popTransDone_i; 1 = host ACKed, 0 = retry.
REQ-012 SHALL have port dataAvailable_o, output, 1: unread entries exist beyond the speculative read pointer.
REQ-013 SHALL have port data_o, output, EP_DATA_WID: entry at the speculative read pointer, first-word-fall-through.

Function
REQ-014 SHALL keep three pointers of width $clog2(DEPTH)+1: wrPtr, rdSpecPtr and rdCommitPtr; the extra MSB is the wrap bit.
REQ-015 SHALL drive dataAvailable_o = (wrPtr != rdSpecPtr), combinationally from registered pointers.
REQ-016 SHALL derive the fill level as wrPtr - rdCommitPtr, modulo 2^($clog2(DEPTH)+1).
REQ-017 SHALL drive freeCount_o = DEPTH - fill level and wrReady_o = (freeCount_o != 0).
REQ-018 SHALL drive data_o = mem[rdSpecPtr[$clog2(DEPTH)-1:0]]; the value is valid only while dataAvailable_o = 1.
REQ-019 SHALL, on an accepted push, write the entry and increment wrPtr at the clock edge; latency to dataAvailable_o is 1 cycle.
REQ-020 SHALL ignore a push while wrReady_o = 0; wrPtr and memory stay unchanged.
REQ-021 SHALL, on popData_i && dataAvailable_o, increment rdSpecPtr; SHALL ignore a pop while dataAvailable_o = 0.
REQ-022 SHALL, on popTransDone_i && popTransSuccess_i, load rdCommitPtr with the next value of rdSpecPtr, so a pop in the same cycle is included in the commit.
REQ-023 SHALL, on popTransDone_i && !popTransSuccess_i, load rdSpecPtr with rdCommitPtr (rollback); a simultaneous popData_i is discarded.
REQ-024 SHALL accept a push in the same cycle as a pop, commit or rollback; all pointer updates are independent.
REQ-025 SHALL use the committed read pointer for full detection, so entries read speculatively are not freed until commit.
REQ-026 SHALL handle wrap-around through the pointer MSB; full = (wrPtr ^ rdCommitPtr) == {1'b1, zeros}.
REQ-027 SHALL treat a commit with no pops since the last commit or rollback as a no-op (zero-length IN packet).
REQ-028 SHALL implement no further state machine; behaviour is fully defined by the three pointers.

Reset
REQ-029 SHALL clear wrPtr, rdSpecPtr and rdCommitPtr to 0 on rst_i, asynchronously.
REQ-030 SHALL drive, during and after reset: dataAvailable_o = 0, wrReady_o = 1, freeCount_o = DEPTH.
REQ-031 SHALL leave memory contents uninitialised; data_o is don't-care while empty.
REQ-032 SHALL, on reset in the middle of a transaction, discard all pending speculative and committed data.

Structure
REQ-033 SHALL take its DEPTH default constant and the EP_IN handshake encoding comments from usb_ep_pkg.
REQ-034 SHALL place storage in sub-module usb_ep_fifo_mem: 1 write port and 1 asynchronous read port, no reset.
REQ-035 SHALL keep pointer arithmetic in usb_ep_in_fifo; one instance per IN endpoint, feeding the EP_IN_* bit slices.

Verification
REQ-036 Basic: push 0x11, 0x22, 0x33; pop 3; commit success -> data_o reads 0x11, 0x22, 0x33 in order; dataAvailable_o = 0; freeCount_o = 64.
REQ-037 Rollback: push 0xA0..0xA3; pop 2; done with success = 0 -> data_o = 0xA0 again; freeCount_o = 60 throughout.
REQ-038 Full: DEPTH = 4; push 4 -> wrReady_o = 0; 5th push ignored; pop 4 without commit -> wrReady_o stays 0; commit -> freeCount_o = 4.
REQ-039 Simultaneous: pop in the same cycle as commit -> included in the commit; pop in the same cycle as rollback -> discarded, rdSpecPtr = rdCommitPtr.
REQ-040 Wrap: DEPTH = 4; run 10 push/pop/commit rounds of 3 bytes -> correct data order and free count across the pointer wrap.
REQ-041 Reset: assert rst_i mid-transaction with 2 speculative pops -> outputs at reset values within the same cycle, asynchronously.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// rtl/usb_ep_pkg.sv - shared USB endpoint constants
// IN transaction result encoding, sampled on popTransSuccess_i with popTransDone_i:
//   1'b1 = EP_IN_ACK   (host acknowledged, speculative reads become permanent)
//   1'b0 = EP_IN_RETRY (no ACK, the packet is replayed from the committed pointer)
package usb_ep_pkg;

  localparam int EP_IN_FIFO_DEPTH = 64;
  localparam int EP_IN_DATA_WID   = 8;

  localparam logic EP_IN_ACK   = 1'b1;
  localparam logic EP_IN_RETRY = 1'b0;

endpackage

// File: rtl/usb_ep_fifo_mem.sv
// rtl/usb_ep_fifo_mem.sv - endpoint FIFO storage, one write port, async read port
// No reset: contents are meaningless until written.
module usb_ep_fifo_mem #(
  parameter int DEPTH = 64,
  parameter int WID   = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           wrEn_i,
  input  logic [AW-1:0]  wrAddr_i,
  input  logic [WID-1:0] wrData_i,
  input  logic [AW-1:0]  rdAddr_i,
  output logic [WID-1:0] rdData_o
);

  logic [WID-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wrEn_i) r_mem[wrAddr_i] <= wrData_i;
  end

  assign rdData_o = r_mem[rdAddr_i];

endmodule

// File: rtl/usb_ep_in_fifo.sv
// rtl/usb_ep_in_fifo.sv - IN endpoint FIFO with speculative read and commit/rollback
// Entries read by the protocol engine are only freed once the host ACKs the packet.
module usb_ep_in_fifo
  import usb_ep_pkg::*;
#(
  parameter int DEPTH       = EP_IN_FIFO_DEPTH,
  parameter int EP_DATA_WID = EP_IN_DATA_WID,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic                   clk48_i,
  input  logic                   rst_i,
  input  logic [EP_DATA_WID-1:0] wrData_i,
  input  logic                   wrValid_i,
  output logic                   wrReady_o,
  output logic [PW-1:0]          freeCount_o,
  input  logic                   popData_i,
  input  logic                   popTransDone_i,
  input  logic                   popTransSuccess_i,
  output logic                   dataAvailable_o,
  output logic [EP_DATA_WID-1:0] data_o
);

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdSpecPtr;
  logic [PW-1:0] r_rdCommitPtr;

  logic [PW-1:0] w_fill;
  logic          w_push;
  logic          w_pop;
  logic          w_ack;
  logic          w_retry;
  logic [PW-1:0] w_rdSpecNext;

  assign w_fill          = r_wrPtr - r_rdCommitPtr;
  assign freeCount_o     = DEPTH_P - w_fill;
  assign wrReady_o       = (freeCount_o != '0);
  assign dataAvailable_o = (r_wrPtr != r_rdSpecPtr);

  assign w_push  = wrValid_i && wrReady_o;
  assign w_pop   = popData_i && dataAvailable_o;
  assign w_ack   = popTransDone_i && (popTransSuccess_i == EP_IN_ACK);
  assign w_retry = popTransDone_i && (popTransSuccess_i == EP_IN_RETRY);

  // Rollback wins over a same-cycle pop; a commit captures that pop.
  always_comb begin
    w_rdSpecNext = r_rdSpecPtr;
    if (w_retry)    w_rdSpecNext = r_rdCommitPtr;
    else if (w_pop) w_rdSpecNext = r_rdSpecPtr + PW'(1);
  end

  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr       <= '0;
      r_rdSpecPtr   <= '0;
      r_rdCommitPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      r_rdSpecPtr <= w_rdSpecNext;
      if (w_ack) r_rdCommitPtr <= w_rdSpecNext;
    end
  end

  usb_ep_fifo_mem #(
    .DEPTH (DEPTH),
    .WID   (EP_DATA_WID)
  ) u_mem (
    .clk_i    (clk48_i),
    .wrEn_i   (w_push),
    .wrAddr_i (r_wrPtr[AW-1:0]),
    .wrData_i (wrData_i),
    .rdAddr_i (r_rdSpecPtr[AW-1:0]),
    .rdData_o (data_o)
  );

endmodule

// File: tb/tb_usb_ep_in_fifo.sv
// tb/tb_usb_ep_in_fifo.sv - bench for usb_ep_in_fifo (64-deep and 4-deep instances)
// Both instances share stimulus; each sequence checks the instance it targets.
module tb_usb_ep_in_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid, pop, done, succ;

  logic       ready64, avail64;
  logic [6:0] free64;
  logic [7:0] data64;
  logic       ready4, avail4;
  logic [2:0] free4;
  logic [7:0] data4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_ep_in_fifo #(.DEPTH(64), .EP_DATA_WID(8)) dut64 (
    .clk48_i(clk), .rst_i(rst), .wrData_i(wr_data), .wrValid_i(wr_valid),
    .wrReady_o(ready64), .freeCount_o(free64), .popData_i(pop),
    .popTransDone_i(done), .popTransSuccess_i(succ),
    .dataAvailable_o(avail64), .data_o(data64)
  );

  usb_ep_in_fifo #(.DEPTH(4), .EP_DATA_WID(8)) dut4 (
    .clk48_i(clk), .rst_i(rst), .wrData_i(wr_data), .wrValid_i(wr_valid),
    .wrReady_o(ready4), .freeCount_o(free4), .popData_i(pop),
    .popTransDone_i(done), .popTransSuccess_i(succ),
    .dataAvailable_o(avail4), .data_o(data4)
  );

  typedef struct {
    logic       push;
    logic [7:0] wd;
    logic       pp;
    logic       dn;
    logic       sc;
    logic       e_avail;
    logic [7:0] e_data;
    logic [6:0] e_free;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(logic p, logic [7:0] w, logic q, logic d, logic s,
                              logic ea, logic [7:0] ed, logic [6:0] ef);
    vec_t v;
    v.push = p; v.wd = w; v.pp = q; v.dn = d; v.sc = s;
    v.e_avail = ea; v.e_data = ed; v.e_free = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [7:0] w, input logic q,
                     input logic d, input logic s);
    @(negedge clk);
    wr_valid = p; wr_data = w; pop = q; done = d; succ = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_valid = 0; wr_data = 0; pop = 0; done = 0; succ = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 0; wr_data = 0; pop = 0; done = 0; succ = 0;
    #1;
    chk("rst_avail64", 32'(avail64), 0);
    chk("rst_free64", 32'(free64), 64);
    chk("rst_ready64", 32'(ready64), 1);
    chk("rst_free4", 32'(free4), 4);
    @(negedge clk);
    rst = 1'b0;

    // push,data,pop,done,succ | expected avail,data,free (before the edge)
    vecs[0]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 64);
    vecs[1]  = mk(1, 8'h11, 0, 0, 0, 0, 8'h00, 64);
    vecs[2]  = mk(1, 8'h22, 0, 0, 0, 1, 8'h11, 63);
    vecs[3]  = mk(1, 8'h33, 0, 0, 0, 1, 8'h11, 62);
    vecs[4]  = mk(0, 8'h00, 1, 0, 0, 1, 8'h11, 61);
    vecs[5]  = mk(0, 8'h00, 1, 0, 0, 1, 8'h22, 61);
    vecs[6]  = mk(0, 8'h00, 1, 0, 0, 1, 8'h33, 61);
    vecs[7]  = mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 61);
    vecs[8]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 64);
    vecs[9]  = mk(1, 8'hA0, 0, 0, 0, 0, 8'h00, 64);
    vecs[10] = mk(1, 8'hA1, 0, 0, 0, 1, 8'hA0, 63);
    vecs[11] = mk(1, 8'hA2, 0, 0, 0, 1, 8'hA0, 62);
    vecs[12] = mk(1, 8'hA3, 0, 0, 0, 1, 8'hA0, 61);
    vecs[13] = mk(0, 8'h00, 1, 0, 0, 1, 8'hA0, 60);
    vecs[14] = mk(0, 8'h00, 1, 0, 0, 1, 8'hA1, 60);
    vecs[15] = mk(0, 8'h00, 0, 1, 0, 1, 8'hA2, 60);
    vecs[16] = mk(0, 8'h00, 0, 0, 0, 1, 8'hA0, 60);
    vecs[17] = mk(0, 8'h00, 1, 1, 1, 1, 8'hA0, 60);
    vecs[18] = mk(0, 8'h00, 0, 0, 0, 1, 8'hA1, 61);
    vecs[19] = mk(0, 8'h00, 1, 0, 0, 1, 8'hA1, 61);
    vecs[20] = mk(0, 8'h00, 1, 1, 0, 1, 8'hA2, 61);
    vecs[21] = mk(0, 8'h00, 0, 0, 0, 1, 8'hA1, 61);
    vecs[22] = mk(0, 8'h00, 1, 0, 0, 1, 8'hA1, 61);
    vecs[23] = mk(0, 8'h00, 1, 0, 0, 1, 8'hA2, 61);
    vecs[24] = mk(0, 8'h00, 1, 1, 1, 1, 8'hA3, 61);
    vecs[25] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 64);
    vecs[26] = mk(0, 8'h00, 1, 1, 1, 0, 8'h00, 64);
    vecs[27] = mk(1, 8'h5C, 1, 0, 0, 0, 8'h00, 64);
    vecs[28] = mk(0, 8'h00, 1, 0, 0, 1, 8'h5C, 63);
    vecs[29] = mk(1, 8'h6D, 0, 1, 1, 0, 8'h00, 63);
    vecs[30] = mk(0, 8'h00, 0, 0, 0, 1, 8'h6D, 63);

    foreach (vecs[i]) begin
      cyc(vecs[i].push, vecs[i].wd, vecs[i].pp, vecs[i].dn, vecs[i].sc);
      #1;
      chk($sformatf("v%0d_avail", i), 32'(avail64), 32'(vecs[i].e_avail));
      chk($sformatf("v%0d_free", i), 32'(free64), 32'(vecs[i].e_free));
      chk($sformatf("v%0d_ready", i), 32'(ready64), 32'(vecs[i].e_free != 0));
      if (vecs[i].e_avail)
        chk($sformatf("v%0d_data", i), 32'(data64), 32'(vecs[i].e_data));
    end

    // Full with DEPTH=4: speculative reads do not free space until commit
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1, 8'(8'h40 + k), 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    #1;
    chk("full_ready", 32'(ready4), 0);
    chk("full_free", 32'(free4), 0);
    chk("full_data", 32'(data4), 32'h40);
    cyc(1, 8'h99, 0, 0, 0);
    #1;
    chk("full_5th_free", 32'(free4), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 8'h00, 1, 0, 0);
      #1;
      chk($sformatf("full_pop%0d_data", k), 32'(data4), 32'(8'h40 + k));
      chk($sformatf("full_pop%0d_ready", k), 32'(ready4), 0);
    end
    cyc(0, 8'h00, 0, 0, 0);
    #1;
    chk("full_drained_avail", 32'(avail4), 0);
    chk("full_drained_ready", 32'(ready4), 0);
    cyc(0, 8'h00, 0, 1, 1);
    cyc(0, 8'h00, 0, 0, 0);
    #1;
    chk("full_commit_free", 32'(free4), 4);
    chk("full_commit_ready", 32'(ready4), 1);
    chk("full_commit_avail", 32'(avail4), 0);

    // Wrap with DEPTH=4: 10 rounds of 3 bytes cross the pointer MSB repeatedly
    do_reset();
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) cyc(1, 8'(r * 3 + k + 1), 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        chk($sformatf("wrap%0d_data%0d", r, k), 32'(data4), 32'(r * 3 + k + 1));
        chk($sformatf("wrap%0d_free%0d", r, k), 32'(free4), 1);
      end
      cyc(0, 8'h00, 0, 1, 1);
      cyc(0, 8'h00, 0, 0, 0);
      #1;
      chk($sformatf("wrap%0d_free", r), 32'(free4), 4);
      chk($sformatf("wrap%0d_avail", r), 32'(avail4), 0);
    end

    // Asynchronous reset in the middle of a transaction
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, 8'(8'h70 + k), 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    #1;
    chk("mid_pre_free", 32'(free64), 61);
    chk("mid_pre_data", 32'(data64), 32'h72);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_avail", 32'(avail64), 0);
    chk("mid_rst_free", 32'(free64), 64);
    chk("mid_rst_ready", 32'(ready64), 1);
    chk("mid_rst_free4", 32'(free4), 4);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 8'h00, 0, 0, 0);
    #1;
    chk("post_rst_avail", 32'(avail64), 0);
    chk("post_rst_free", 32'(free64), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
